// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg: shared state encoding, polynomials and step functions for the gate BIST controller
package gate_bist_pkg;
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [9:0] MISR_POLY = 10'h008;
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction
    function automatic logic [9:0] misr_next(input logic [9:0] m, input logic [9:0] r);
        return {m[8:0], m[9]} ^ (m[9] ? MISR_POLY : 10'h000) ^ r;
    endfunction
endpackage

// File: rtl/bist_misr.sv
// bist_misr: multiple-input signature register compacting gate responses
module bist_misr
    import gate_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [9:0] seed,
    input  logic [9:0] resp_in,
    output logic [9:0] sig
);
    always_ff @(posedge clk or posedge rst)
        if (rst) sig <= '0;
        else if (load) sig <= seed;
        else if (en) sig <= misr_next(sig, resp_in);
endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: LFSR-driven BIST sequencer for one combinational gate model with MISR signature check
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int OUT_WIDTH = 10,
    parameter int PATTERN_COUNT = 256,
    parameter int SETTLE_CYCLES = 1,
    parameter logic [IN_WIDTH-1:0] LFSR_SEED = 16'hACE1,
    parameter logic [OUT_WIDTH-1:0] MISR_SEED = 10'h000
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [OUT_WIDTH-1:0] expected_sig,
    input  logic [OUT_WIDTH-1:0] resp_in,
    output logic [IN_WIDTH-1:0]  pat_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [OUT_WIDTH-1:0] signature
);
    localparam int PW = PATTERN_COUNT > 1 ? $clog2(PATTERN_COUNT) : 1;
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    state_t state;
    logic [PW-1:0] pcnt;
    logic [SW-1:0] scnt;
    logic capture, last, load;
    assign capture = state == APPLY && scnt == SW'(SETTLE_CYCLES - 1);
    assign last = pcnt == PW'(PATTERN_COUNT - 1);
    // start is honoured only outside APPLY and always loses to abort
    assign load = start && !abort && state != APPLY;
    assign pass = done && signature == expected_sig;
    bist_misr u_misr (
        .clk(clk),
        .rst(rst),
        .load(load),
        .en(capture && !abort),
        .seed(MISR_SEED),
        .resp_in(resp_in),
        .sig(signature)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            pat_out <= '0;
            pcnt <= '0;
            scnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            pcnt <= '0;
            scnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            state <= APPLY;
            pat_out <= LFSR_SEED;
            pcnt <= '0;
            scnt <= '0;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (capture) begin
            pat_out <= lfsr_next(pat_out);
            pcnt <= pcnt + PW'(1);
            scnt <= '0;
            if (last) begin
                state <= DONE;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else if (state == APPLY) scnt <= scnt + SW'(1);
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: directed checks of three controller configurations against hand-computed values
module tb_gate_bist_ctrl;
    logic clk = 0, rst = 1, abort = 0;
    logic start_a = 0, start_b = 0, start_c = 0;
    logic [9:0] exp_a = 10'h00C, exp_b = 0, exp_c = 0, resp_b = 0, resp_c = 0;
    logic [9:0] resp_a, sig_a, sig_b, sig_c;
    logic [15:0] pat_a, pat_b, pat_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
    int n_checks = 0, n_fail = 0;
    always #5 clk = ~clk;
    // gate model stand-in: low ten input bits feed straight through
    assign resp_a = pat_a[9:0];
    gate_bist_ctrl #(.PATTERN_COUNT(4), .SETTLE_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .expected_sig(exp_a), .resp_in(resp_a),
        .pat_out(pat_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));
    gate_bist_ctrl #(.PATTERN_COUNT(2), .SETTLE_CYCLES(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .expected_sig(exp_b), .resp_in(resp_b),
        .pat_out(pat_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));
    gate_bist_ctrl #(.PATTERN_COUNT(2), .SETTLE_CYCLES(3)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(abort), .expected_sig(exp_c), .resp_in(resp_c),
        .pat_out(pat_c), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        #2;
        @(negedge clk);
        rst = 0;
        repeat (5) tick();
        n_checks++; if (pat_a !== 16'h0) begin n_fail++; $display("FAIL reset_pat got %h exp 0000", pat_a); end
        n_checks++; if (sig_a !== 10'h0) begin n_fail++; $display("FAIL reset_sig got %h exp 000", sig_a); end
        n_checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {busy_a, done_a, pass_a}); end
        n_checks++; if ({busy_c, done_c, pass_c, sig_c} !== 13'h0) begin n_fail++; $display("FAIL reset_c got %b exp 0", {busy_c, done_c, pass_c, sig_c}); end
    endtask

    task automatic test_sequence();
        logic [15:0] pats [4] = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F};
        start_a = 1;
        tick();
        start_a = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (pat_a !== pats[i]) begin n_fail++; $display("FAIL seq_pat%0d got %h exp %h", i, pat_a, pats[i]); end
            n_checks++; if ({busy_a, done_a} !== 2'b10) begin n_fail++; $display("FAIL seq_flags%0d got %b exp 10", i, {busy_a, done_a}); end
            tick();
        end
        n_checks++; if ({busy_a, done_a, pass_a} !== 3'b011) begin n_fail++; $display("FAIL seq_done got %b exp 011", {busy_a, done_a, pass_a}); end
        n_checks++; if (sig_a !== 10'h00C) begin n_fail++; $display("FAIL seq_sig got %h exp 00c", sig_a); end
        n_checks++; if (pat_a !== 16'hCE1E) begin n_fail++; $display("FAIL seq_final_pat got %h exp ce1e", pat_a); end
        tick();
        n_checks++; if ({done_a, sig_a, pat_a} !== {1'b1, 10'h00C, 16'hCE1E}) begin n_fail++; $display("FAIL seq_hold got %b %h %h exp 1 00c ce1e", done_a, sig_a, pat_a); end
    endtask

    task automatic test_signature();
        resp_b = 10'h001;
        exp_b = 10'h003;
        start_b = 1;
        tick();
        start_b = 0;
        n_checks++; if ({busy_b, sig_b, pass_b} !== {1'b1, 10'h000, 1'b0}) begin n_fail++; $display("FAIL sig_load got %b %h %b exp 1 000 0", busy_b, sig_b, pass_b); end
        tick();
        n_checks++; if (sig_b !== 10'h001) begin n_fail++; $display("FAIL sig_first got %h exp 001", sig_b); end
        tick();
        n_checks++; if ({done_b, sig_b} !== {1'b1, 10'h003}) begin n_fail++; $display("FAIL sig_second got %b %h exp 1 003", done_b, sig_b); end
        n_checks++; if (pass_b !== 1'b1) begin n_fail++; $display("FAIL sig_pass got %b exp 1", pass_b); end
        exp_b = 10'h002;
        #1;
        n_checks++; if (pass_b !== 1'b0) begin n_fail++; $display("FAIL sig_nopass got %b exp 0", pass_b); end
    endtask

    task automatic test_settle();
        int busy_cycles = 0;
        start_c = 1;
        resp_c = 10'h3FF;
        for (int c = 1; c <= 7; c++) begin
            tick();
            start_c = 0;
            busy_cycles += int'(busy_c);
            if (c <= 6) begin
                n_checks++;
                if (pat_c !== (c <= 3 ? 16'hACE1 : 16'h59C3)) begin n_fail++; $display("FAIL settle_pat%0d got %h", c, pat_c); end
            end
            resp_c = (c + 1 == 4) ? 10'h010 : (c + 1 == 7) ? 10'h005 : 10'h3FF ^ 10'(c);
        end
        n_checks++; if (busy_cycles != 6) begin n_fail++; $display("FAIL settle_busy got %0d exp 6", busy_cycles); end
        n_checks++; if ({done_c, sig_c} !== {1'b1, 10'h025}) begin n_fail++; $display("FAIL settle_sig got %b %h exp 1 025", done_c, sig_c); end
    endtask

    task automatic test_abort();
        start_a = 1;
        abort = 1;
        tick();
        start_a = 0;
        abort = 0;
        n_checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin n_fail++; $display("FAIL abort_wins got %b exp 000", {busy_a, done_a, pass_a}); end
        start_a = 1;
        tick();
        start_a = 0;
        tick();
        abort = 1;
        tick();
        abort = 0;
        n_checks++; if ({busy_a, done_a, pass_a} !== 3'b000) begin n_fail++; $display("FAIL abort_idle got %b exp 000", {busy_a, done_a, pass_a}); end
        n_checks++; if ({pat_a, sig_a} !== {16'h59C3, 10'h0E1}) begin n_fail++; $display("FAIL abort_hold got %h %h exp 59c3 0e1", pat_a, sig_a); end
        start_a = 1;
        tick();
        start_a = 0;
        repeat (4) tick();
        n_checks++; if ({done_a, pass_a, sig_a} !== {2'b11, 10'h00C}) begin n_fail++; $display("FAIL abort_rerun got %b %b %h exp 1 1 00c", done_a, pass_a, sig_a); end
    endtask

    task automatic test_async_reset();
        start_a = 1;
        tick();
        start_a = 0;
        tick();
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        n_checks++; if ({pat_a, sig_a, busy_a, done_a, pass_a} !== 29'h0) begin n_fail++; $display("FAIL async_rst got %h %h %b%b%b exp all 0", pat_a, sig_a, busy_a, done_a, pass_a); end
        @(negedge clk);
        rst = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        start_a = 1;
        tick();
        n_checks++; if ({busy_a, pat_a} !== {1'b1, 16'hACE1}) begin n_fail++; $display("FAIL b2b_first got %b %h exp 1 ace1", busy_a, pat_a); end
        repeat (4) tick();
        n_checks++; if ({done_a, sig_a} !== {1'b1, 10'h00C}) begin n_fail++; $display("FAIL b2b_done got %b %h exp 1 00c", done_a, sig_a); end
        tick();
        n_checks++; if ({busy_a, done_a, pat_a} !== {2'b10, 16'hACE1}) begin n_fail++; $display("FAIL b2b_restart got %b%b %h exp 10 ace1", busy_a, done_a, pat_a); end
        start_a = 0;
        abort = 1;
        tick();
        abort = 0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_signature();
        test_settle();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_bist_ctrl.md
# gate_bist_ctrl

Built-in self-test controller that exercises one combinational gate model from the simulator gate library (16 inputs, 10 outputs). An LFSR pattern generator drives the gate model inputs. A MISR compacts the gate model outputs into a signature. A small FSM sequences a fixed number of patterns and compares the result against an expected signature. It sits beside each library gate model in the simulator test harness and closes the loop the gate model leaves open.

## Interface
- IN_WIDTH, 16: gate model input width (LFSR width); fixed at 16 because the polynomial is defined for 16 bits.
- OUT_WIDTH, 10: gate model output width (MISR width); fixed at 10 because the polynomial is defined for 10 bits.
- PATTERN_COUNT, 256: number of patterns per run, ≥1.
- SETTLE_CYCLES, 1: cycles each pattern is held before capture, ≥1.
- LFSR_SEED, 16'hACE1: first pattern applied; must be nonzero.
- MISR_SEED, 10'h000: signature start value.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin run; sampled in IDLE and DONE only.
- abort  in  1  return to IDLE from any state; has priority over start.
- expected_sig  in  OUT_WIDTH  golden signature; sampled in DONE.
- resp_in  in  OUT_WIDTH  gate model outputs.
- pat_out  out  IN_WIDTH  gate model inputs; equals the LFSR register.
- busy  out  1  high in APPLY.
- done  out  1  high in DONE.
- pass  out  1  in DONE: signature == expected_sig; 0 otherwise.
- signature  out  OUT_WIDTH  MISR register.

## Operation
- States: IDLE, APPLY, DONE. Reset enters IDLE.
- Reset values: pat_out=0, signature=0, busy=0, done=0, pass=0, pattern counter=0, settle counter=0.
- IDLE, start=1:
  - Load LFSR=LFSR_SEED and MISR=MISR_SEED.
  - Clear both counters.
  - Go to APPLY.
- APPLY: the settle counter counts 0..SETTLE_CYCLES-1. On the edge where the settle counter equals SETTLE_CYCLES-1 (the capture edge):
  - MISR <= misr_next(MISR, resp_in).
  - LFSR steps.
  - Pattern counter increments; settle counter clears.
  - If the pattern counter was PATTERN_COUNT-1, go to DONE; otherwise stay in APPLY.
- start is ignored in APPLY.
- DONE:
  - Holds the signature and the final stepped LFSR value.
  - pass is combinational from signature and expected_sig, gated by done.
  - start=1 reloads the seeds and clears the counters, exactly as from IDLE, and goes to APPLY.
- abort=1 in any state: go to IDLE on the next edge.
  - Counters clear.
  - pat_out and signature hold their values.
  - done and pass drop.
- LFSR step, Fibonacci x^16+x^14+x^13+x^11+1:
  - fb = L[15]^L[13]^L[12]^L[10].
  - L <= {L[14:0], fb}.
- MISR step, x^10+x^3+1:
  - next[0] = M[9]^R[0].
  - next[i] = M[i-1]^R[i] for i=1..9, with M[9] additionally XORed into next[3].
- Counter widths are $clog2 of each count; when the count is 1, the width is 1.

## Timing
- The gate model is combinational. resp_in must be valid within SETTLE_CYCLES cycles of a pat_out change, and is sampled only on capture edges.
- After the edge that samples start, busy=1 and pat_out=LFSR_SEED.
- Pattern k (k=0..PATTERN_COUNT-1) is on pat_out for exactly SETTLE_CYCLES cycles.
- Run length from first busy cycle to first done cycle: PATTERN_COUNT*SETTLE_CYCLES cycles.
- busy falls and done rises on the last capture edge; the signature is final in that same cycle.
- abort and start in the same cycle: abort wins.
- Asynchronous rst mid-run: all outputs go to their reset values immediately, with no clock required.

## Structure
- Shared package gate_bist_pkg holds:
  - state enum (IDLE, APPLY, DONE);
  - LFSR tap mask 16'hB400;
  - MISR feedback mask 10'h008;
  - functions lfsr_next and misr_next.
- One natural sub-module, bist_misr: a MISR register with load, enable, seed and resp_in. The LFSR stays inline.

## Test plan
- Reset, then idle for 5 cycles -> pat_out=0, signature=0, busy=0, done=0, pass=0.
- PATTERN_COUNT=4, SETTLE_CYCLES=1, one-cycle start pulse -> pat_out sequence 16'hACE1, 16'h59C3, 16'hB387, …; done rises exactly 4 cycles after busy rises.
- PATTERN_COUNT=2, resp_in held at 10'h001, MISR_SEED=0 -> signature 10'h001 then 10'h003; expected_sig=10'h003 gives pass=1, expected_sig=10'h002 gives pass=0.
- SETTLE_CYCLES=3, PATTERN_COUNT=2 -> each pattern held 3 cycles; resp_in changed on non-capture cycles does not affect the signature; busy is high for 6 cycles.
- abort asserted in cycle 2 of a run -> IDLE next edge; done=0; a later start reproduces the full-run signature bit-exactly.
- rst asserted asynchronously mid-APPLY, off the clock edge -> outputs go to zero before the next edge; start in DONE (including a start held high) -> restarts from LFSR_SEED.
